pipelined_cla_addsub: RTL and testbench



---
 rtl/pipelined_cla_addsub_if.sv | 58 +++++
 rtl/pipelined_cla_addsub.sv | 167 ++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Handshake/bus bundle for pipelined_cla_addsub.
//
// Signals:
//   in_valid  - operand set presented (master -> slave)
//   in_ready  - unit accepts operands this cycle (slave -> master)
//   a, b      - operands, WIDTH bits
//   cin       - carry-in for add, borrow-in for subtract
//   sub       - 0: a + b + cin, 1: a - b - cin
//   out_valid - result valid (slave -> master)
//   out_ready - downstream accepts result (master -> slave)
//   s         - sum/difference, WIDTH bits
//   cout      - raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf       - two's-complement signed overflow
//
// WIDTH must match the WIDTH of the adder instance the bundle connects to.
interface pipelined_cla_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  s,
        input  cout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output s,
        output cout,
        output ovf
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor.
//
// The operand width is cut into NSEG = WIDTH / SEG_W look-ahead segments. Segment k is
// resolved in pipeline stage k from the carry registered by stage k-1 (stage 0 takes the
// prepared carry-in directly at accept time). Operand bits that have not been consumed yet
// ride along in skew registers; finished low sum bits ride along in deskew registers so the
// last stage presents the whole result at once. One operation per cycle is sustained; any
// backpressure stalls every stage together.
//
// Parameters:
//   WIDTH - operand/result width, a multiple of SEG_W
//   SEG_W - bits per look-ahead segment (2..8)
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; drops all in-flight work
//   bus   - pipelined_cla_addsub_if slave modport (operands, handshake, result)
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_cla_addsub_if.slave bus
);

    localparam int unsigned NSEG = WIDTH / SEG_W;

    // Carries into every bit of a segment plus the segment carry-out, each written as a
    // flat AND-OR of generate/propagate terms so no carry ripples through the segment.
    // c[i] is the carry into bit i; c[SEG_W] is the carry out of the segment.
    function automatic logic [SEG_W:0] seg_carries(
        input logic [SEG_W-1:0] p,
        input logic [SEG_W-1:0] g,
        input logic             c0
    );
        logic [SEG_W:0] c;
        logic           prod;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < SEG_W; i++) begin
            prod = c0;
            for (int m = 0; m <= i; m++) begin
                prod = prod & p[m];
            end
            c[i+1] = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                c[i+1] = c[i+1] | prod;
            end
        end
        return c;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is a + ~b + ~cin: with cin = 0 that is exactly a - b.
    always_comb begin
        advance = !bus.out_valid || bus.out_ready;
        b_eff   = bus.sub ? ~bus.b : bus.b;
        c_eff   = bus.sub ? ~bus.cin : bus.cin;
    end

    assign bus.in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : gen_stage
        logic [SEG_W-1:0]         a_seg;
        logic [SEG_W-1:0]         b_seg;
        logic                     c_in;
        logic                     valid_d;
        logic [SEG_W-1:0]         p;
        logic [SEG_W-1:0]         g;
        logic [SEG_W:0]           c;
        logic [SEG_W-1:0]         seg_sum;
        logic [(k+1)*SEG_W-1:0]   sum_d;
        logic                     valid_q;
        logic                     carry_q;
        logic [(k+1)*SEG_W-1:0]   sum_q;

        if (k == 0) begin : gen_first
            assign a_seg   = bus.a[SEG_W-1:0];
            assign b_seg   = b_eff[SEG_W-1:0];
            assign c_in    = c_eff;
            assign valid_d = bus.in_valid;
            assign sum_d   = seg_sum;
        end else begin : gen_next
            assign a_seg   = gen_stage[k-1].gen_skew.a_rest_q[SEG_W-1:0];
            assign b_seg   = gen_stage[k-1].gen_skew.b_rest_q[SEG_W-1:0];
            assign c_in    = gen_stage[k-1].carry_q;
            assign valid_d = gen_stage[k-1].valid_q;
            assign sum_d   = {seg_sum, gen_stage[k-1].sum_q};
        end

        always_comb begin
            p       = a_seg ^ b_seg;
            g       = a_seg & b_seg;
            c       = seg_carries(p, g, c_in);
            seg_sum = p ^ c[SEG_W-1:0];
        end

        // Data registers load on every advance, bubbles included; only valid_q says
        // whether the contents mean anything.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= c[SEG_W];
                sum_q   <= sum_d;
            end
        end

        // Skew registers: operand segments k+1 .. NSEG-1 still waiting for their stage.
        if (k < NSEG - 1) begin : gen_skew
            localparam int unsigned RW = (NSEG - 1 - k) * SEG_W;

            logic [RW-1:0] a_rest_d;
            logic [RW-1:0] b_rest_d;
            logic [RW-1:0] a_rest_q;
            logic [RW-1:0] b_rest_q;

            if (k == 0) begin : gen_src_in
                assign a_rest_d = bus.a[WIDTH-1:SEG_W];
                assign b_rest_d = b_eff[WIDTH-1:SEG_W];
            end else begin : gen_src_prev
                assign a_rest_d = gen_stage[k-1].gen_skew.a_rest_q[RW+SEG_W-1:SEG_W];
                assign b_rest_d = gen_stage[k-1].gen_skew.b_rest_q[RW+SEG_W-1:SEG_W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rest_q <= '0;
                    b_rest_q <= '0;
                end else if (advance) begin
                    a_rest_q <= a_rest_d;
                    b_rest_q <= b_rest_d;
                end
            end
        end

        // Signed overflow: carry into the MSB differs from carry out of the MSB.
        if (k == NSEG - 1) begin : gen_last
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= c[SEG_W] ^ c[SEG_W-1];
                end
            end
        end
    end

    assign bus.out_valid = gen_stage[NSEG-1].valid_q;
    assign bus.s         = gen_stage[NSEG-1].sum_q;
    assign bus.cout      = gen_stage[NSEG-1].carry_q;
    assign bus.ovf       = gen_stage[NSEG-1].gen_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Testbench for pipelined_cla_addsub: three instances (8/2, 16/4, 32/8) share one stimulus
// source. Directed vectors on the 16-bit unit, a backpressure scenario, a mid-stream reset
// and a random back-to-back stream checked on all widths against an arithmetic model.
module tb_pipelined_cla_addsub;

    localparam int NSEG = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid_d = 1'b0;
    logic        cin_d = 1'b0;
    logic        sub_d = 1'b0;
    logic        out_ready_d = 1'b1;
    logic [31:0] a_d = '0;
    logic [31:0] b_d = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pipelined_cla_addsub_if #(.WIDTH(8))  if8 ();
    pipelined_cla_addsub_if #(.WIDTH(16)) if16 ();
    pipelined_cla_addsub_if #(.WIDTH(32)) if32 ();

    assign if8.in_valid   = in_valid_d;
    assign if8.a          = a_d[7:0];
    assign if8.b          = b_d[7:0];
    assign if8.cin        = cin_d;
    assign if8.sub        = sub_d;
    assign if8.out_ready  = out_ready_d;
    assign if16.in_valid  = in_valid_d;
    assign if16.a         = a_d[15:0];
    assign if16.b         = b_d[15:0];
    assign if16.cin       = cin_d;
    assign if16.sub       = sub_d;
    assign if16.out_ready = out_ready_d;
    assign if32.in_valid  = in_valid_d;
    assign if32.a         = a_d;
    assign if32.b         = b_d;
    assign if32.cin       = cin_d;
    assign if32.sub       = sub_d;
    assign if32.out_ready = out_ready_d;

    pipelined_cla_addsub #(.WIDTH(8), .SEG_W(2)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );
    pipelined_cla_addsub #(.WIDTH(16), .SEG_W(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );
    pipelined_cla_addsub #(.WIDTH(32), .SEG_W(8)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    // Index 0/1/2 = width 8/16/32.
    logic [2:0]  ov_w;
    logic [2:0]  ir_w;
    logic [2:0]  co_w;
    logic [2:0]  of_w;
    logic [31:0] s_w [3];
    assign ov_w   = {if32.out_valid, if16.out_valid, if8.out_valid};
    assign ir_w   = {if32.in_ready, if16.in_ready, if8.in_ready};
    assign co_w   = {if32.cout, if16.cout, if8.cout};
    assign of_w   = {if32.ovf, if16.ovf, if8.ovf};
    assign s_w[0] = {24'd0, if8.s};
    assign s_w[1] = {16'd0, if16.s};
    assign s_w[2] = if32.s;

    // Returns {ovf, cout, s} for a w-bit add/sub.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
        logic [32:0] mask;
        logic [32:0] aa;
        logic [32:0] bb;
        logic [32:0] full;
        logic        sa;
        logic        sb;
        logic        ss;
        mask = (33'd1 << w) - 33'd1;
        aa   = {1'b0, a} & mask;
        bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full = aa + bb + {32'd0, sub ^ cin};
        sa   = aa[w-1];
        sb   = bb[w-1];
        ss   = full[w-1];
        return {(sa == sb) && (ss != sa), full[w], full[31:0] & mask[31:0]};
    endfunction

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid_d  = 1'b0;
        out_ready_d = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ov_w[k], ir_w[k], co_w[k], of_w[k]} !== 4'b0100)
                $display("FAIL reset_flags w=%0d: got v/r/c/o=%b, want 0100", 8 << k,
                         {ov_w[k], ir_w[k], co_w[k], of_w[k]});
            else n_pass++;
            n_checks++;
            if (s_w[k] !== 32'd0)
                $display("FAIL reset_s w=%0d: got %h, want 0", 8 << k, s_w[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t dir [10];
        dir[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        dir[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        dir[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        dir[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        dir[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        dir[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        dir[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        dir[7] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        dir[8] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        dir[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready_d = 1'b1;
            in_valid_d  = 1'b1;
            a_d         = {16'd0, dir[i].a};
            b_d         = {16'd0, dir[i].b};
            cin_d       = dir[i].cin;
            sub_d       = dir[i].sub;
            #1;
            n_checks++;
            if (if16.in_ready !== 1'b1)
                $display("FAIL dir_in_ready[%0d]: got %b, want 1", i, if16.in_ready);
            else n_pass++;
            for (int c = 1; c <= NSEG + 1; c++) begin
                @(negedge clk);
                in_valid_d = 1'b0;
                #1;
                n_checks++;
                if (if16.out_valid !== (c == NSEG))
                    $display("FAIL dir_latency[%0d] cycle %0d: got out_valid=%b, want %b",
                             i, c, if16.out_valid, c == NSEG);
                else n_pass++;
                if (c == NSEG) begin
                    n_checks++;
                    if ({if16.s, if16.cout, if16.ovf} !== {dir[i].s, dir[i].co, dir[i].ov})
                        $display("FAIL dir_result[%0d]: got s=%h c=%b o=%b, want s=%h c=%b o=%b",
                                 i, if16.s, if16.cout, if16.ovf, dir[i].s, dir[i].co,
                                 dir[i].ov);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_stall();
        vec_t ops [6];
        int   n_iss = 0;
        int   n_got = 0;
        ops[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        ops[1] = '{16'h1000, 16'h0FFF, 1'b0, 1'b0, 16'h1FFF, 1'b0, 1'b0};
        ops[2] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
        ops[3] = '{16'hFFF0, 16'h0020, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
        ops[4] = '{16'h2222, 16'h1111, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
        ops[5] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready_d = !(cyc >= 4 && cyc < 10);
            in_valid_d  = (n_iss < 6);
            if (n_iss < 6) begin
                a_d   = {16'd0, ops[n_iss].a};
                b_d   = {16'd0, ops[n_iss].b};
                cin_d = ops[n_iss].cin;
                sub_d = ops[n_iss].sub;
            end
            #1;
            if (!out_ready_d) begin
                n_checks++;
                if (if16.in_ready !== 1'b0)
                    $display("FAIL stall_in_ready cycle %0d: got %b, want 0", cyc,
                             if16.in_ready);
                else n_pass++;
                n_checks++;
                if ({if16.out_valid, if16.s, if16.cout, if16.ovf} !==
                    {1'b1, ops[0].s, ops[0].co, ops[0].ov})
                    $display("FAIL stall_hold cycle %0d: got v=%b s=%h c=%b o=%b, want v=1 s=%h",
                             cyc, if16.out_valid, if16.s, if16.cout, if16.ovf, ops[0].s);
                else n_pass++;
            end
            if (if16.out_valid && out_ready_d) begin
                n_checks++;
                if (n_got >= 6)
                    $display("FAIL stall_extra_result: got s=%h, want no result", if16.s);
                else if ({if16.s, if16.cout, if16.ovf} !==
                         {ops[n_got].s, ops[n_got].co, ops[n_got].ov})
                    $display("FAIL stall_result[%0d]: got s=%h c=%b o=%b, want s=%h c=%b o=%b",
                             n_got, if16.s, if16.cout, if16.ovf, ops[n_got].s, ops[n_got].co,
                             ops[n_got].ov);
                else n_pass++;
                n_got++;
            end
            if (in_valid_d && if16.in_ready) n_iss++;
        end
        in_valid_d = 1'b0;
        n_checks++;
        if (n_got !== 6) $display("FAIL stall_count: got %0d results, want 6", n_got);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra [100];
        logic [31:0] rb [100];
        logic        rc [100];
        logic        rs [100];
        int          n_got [3];
        int          n_iss = 0;
        int          n_drop = 0;
        int          first = -1;
        int          last = -1;
        logic [33:0] exp;
        for (int i = 0; i < 100; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 3; k++) n_got[k] = 0;
        for (int cyc = 0; cyc < 140; cyc++) begin
            @(negedge clk);
            out_ready_d = 1'b1;
            in_valid_d  = (n_iss < 100);
            if (n_iss < 100) begin
                a_d   = ra[n_iss];
                b_d   = rb[n_iss];
                cin_d = rc[n_iss];
                sub_d = rs[n_iss];
            end
            #1;
            if (ir_w !== 3'b111) n_drop++;
            for (int k = 0; k < 3; k++) begin
                if (ov_w[k]) begin
                    n_checks++;
                    if (n_got[k] >= 100) begin
                        $display("FAIL b2b_extra w=%0d: got s=%h, want no result", 8 << k,
                                 s_w[k]);
                    end else begin
                        exp = model(8 << k, ra[n_got[k]], rb[n_got[k]], rc[n_got[k]],
                                    rs[n_got[k]]);
                        if ({of_w[k], co_w[k], s_w[k]} !== exp)
                            $display("FAIL b2b_result w=%0d op %0d: got o/c/s=%b/%b/%h, want %b/%b/%h",
                                     8 << k, n_got[k], of_w[k], co_w[k], s_w[k], exp[33],
                                     exp[32], exp[31:0]);
                        else n_pass++;
                    end
                    if (k == 1) begin
                        if (first < 0) first = cyc;
                        last = cyc;
                    end
                    n_got[k]++;
                end
            end
            if (in_valid_d && if16.in_ready) n_iss++;
        end
        in_valid_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (n_got[k] !== 100)
                $display("FAIL b2b_count w=%0d: got %0d results, want 100", 8 << k, n_got[k]);
            else n_pass++;
        end
        n_checks++;
        if (n_drop !== 0) $display("FAIL b2b_in_ready: got %0d low cycles, want 0", n_drop);
        else n_pass++;
        n_checks++;
        if (last - first !== 99)
            $display("FAIL b2b_full_rate: got span %0d cycles, want 99", last - first);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        out_ready_d = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid_d = 1'b1;
            a_d        = 32'h0000_F000 + 32'(i);
            b_d        = 32'h0000_1000;
            cin_d      = 1'b0;
            sub_d      = 1'b0;
        end
        @(posedge clk);
        #2;
        n_checks++;
        if ({if16.out_valid, if16.s, if16.cout} !== {1'b1, 16'h0003, 1'b1})
            $display("FAIL rst_pre_state: got v=%b s=%h c=%b, want v=1 s=0003 c=1",
                     if16.out_valid, if16.s, if16.cout);
        else n_pass++;
        rst_n      = 1'b0;
        in_valid_d = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ov_w[k], ir_w[k], co_w[k], of_w[k], s_w[k]} !== {4'b0100, 32'd0})
                $display("FAIL rst_async w=%0d: got v/r/c/o=%b s=%h, want 0100 s=0", 8 << k,
                         {ov_w[k], ir_w[k], co_w[k], of_w[k]}, s_w[k]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        in_valid_d = 1'b1;
        a_d        = 32'h0000_0003;
        b_d        = 32'h0000_0004;
        #1;
        n_checks++;
        if (if16.in_ready !== 1'b1)
            $display("FAIL rst_first_ready: got %b, want 1", if16.in_ready);
        else n_pass++;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid_d = 1'b0;
            #1;
            n_checks++;
            if (if16.out_valid !== (c == NSEG))
                $display("FAIL rst_stale cycle %0d: got out_valid=%b, want %b", c,
                         if16.out_valid, c == NSEG);
            else n_pass++;
            if (c == NSEG) begin
                n_checks++;
                if ({if16.s, if16.cout, if16.ovf} !== {16'h0007, 1'b0, 1'b0})
                    $display("FAIL rst_fresh_result: got s=%h c=%b o=%b, want s=0007 c=0 o=0",
                             if16.s, if16.cout, if16.ovf);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
